// File: rtl/wb_regfile_unit.sv
// Writeback stage merged with the architectural register file.
// Picks the retiring value (load data over ALU result), commits it to one of
// NUM_REGS GPRs, commits compare flags to the CPSR, and holds the fetch PC.
// All read ports are combinational from stored state; there is no write bypass.
module wb_regfile_unit #(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 16,
   localparam int IDX_W   = $clog2(NUM_REGS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [IDX_W-1:0]  rd_num_passthrough,
   input  logic [DATA_W-1:0] md_passthrough,
   input  logic [DATA_W-1:0] result,
   input  logic [DATA_W-1:0] cpsr_passthrough,
   input  logic [DATA_W-1:0] dmem_val_passthrough,
   input  logic              is_alu_op_passthrough,
   input  logic              is_cmp_op_passthrough,
   input  logic              is_ld_op_passthrough,
   input  logic [DATA_W-1:0] if_pc_in,
   output logic [DATA_W-1:0] if_pc_out,
   input  logic [IDX_W-1:0]  exe_rd_num,
   output logic [DATA_W-1:0] exe_rd_data_out,
   input  logic [IDX_W-1:0]  exe_rs_num,
   output logic [DATA_W-1:0] exe_rs_data_out,
   input  logic [IDX_W-1:0]  exe_rt_num,
   output logic [DATA_W-1:0] exe_rt_data_out,
   output logic [DATA_W-1:0] exe_cpsr_out,
   output logic [IDX_W-1:0]  wb_rd_num,
   output logic              wb_rd_write_en,
   output logic [DATA_W-1:0] wb_rd_val,
   output logic              wb_cpsr_write_en,
   output logic [DATA_W-1:0] wb_cpsr_val,
   output logic [DATA_W-1:0] wb_rd_out,
   output logic [DATA_W-1:0] wb_cpsr_out
);

   logic [DATA_W-1:0] gpr_q [NUM_REGS];
   logic [DATA_W-1:0] gpr_d [NUM_REGS];
   logic [DATA_W-1:0] cpsr_q, cpsr_d;
   logic [DATA_W-1:0] pc_q, pc_d;

   // Store data travels alongside but is consumed by the memory stage, not here.
   logic unused_md;
   assign unused_md = ^md_passthrough;

   // Writeback select: load data takes priority when both ALU and load are flagged.
   assign wb_rd_num        = rd_num_passthrough;
   assign wb_rd_write_en   = is_alu_op_passthrough | is_ld_op_passthrough;
   assign wb_rd_val        = is_ld_op_passthrough ? dmem_val_passthrough : result;
   assign wb_cpsr_write_en = is_cmp_op_passthrough;
   assign wb_cpsr_val      = cpsr_passthrough;

   // Next-state for the register file, CPSR and PC.
   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         gpr_d[i] = gpr_q[i];
      end
      if (wb_rd_write_en) begin
         gpr_d[wb_rd_num] = wb_rd_val;
      end
      cpsr_d = wb_cpsr_write_en ? wb_cpsr_val : cpsr_q;
      pc_d   = if_pc_in;
   end

   // State registers; reset clears everything immediately and blocks writes while low.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            gpr_q[i] <= '0;
         end
         cpsr_q <= '0;
         pc_q   <= '0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            gpr_q[i] <= gpr_d[i];
         end
         cpsr_q <= cpsr_d;
         pc_q   <= pc_d;
      end
   end

   // Read ports see stored state only; a same-cycle write shows up after the edge.
   assign exe_rd_data_out = gpr_q[exe_rd_num];
   assign exe_rs_data_out = gpr_q[exe_rs_num];
   assign exe_rt_data_out = gpr_q[exe_rt_num];
   assign exe_cpsr_out    = cpsr_q;
   assign if_pc_out       = pc_q;
   assign wb_rd_out       = gpr_q[wb_rd_num];
   assign wb_cpsr_out     = cpsr_q;

endmodule

// File: tb/tb_wb_regfile_unit.sv
// Bench for wb_regfile_unit: directed plan steps plus a randomized run, all
// checked against a plain array model of the GPRs, CPSR and PC.
module tb_wb_regfile_unit;

   logic        clk;
   logic        reset;
   logic [3:0]  rd_num;
   logic [31:0] md, result, cpsr_pt, dmem, pc_in;
   logic        is_alu, is_cmp, is_ld;
   logic [3:0]  rdn, rsn, rtn;
   logic [31:0] pc_out, rd_data, rs_data, rt_data, cpsr_out;
   logic [3:0]  wb_rd_num;
   logic        wb_rd_we, wb_cpsr_we;
   logic [31:0] wb_rd_val, wb_cpsr_val, wb_rd_out, wb_cpsr_out;

   int vectors = 0;
   int miscompares = 0;

   logic [31:0] ref_gpr [16];
   logic [31:0] ref_cpsr;
   logic [31:0] ref_pc;

   wb_regfile_unit dut (
      .clk                   (clk),
      .reset                 (reset),
      .rd_num_passthrough    (rd_num),
      .md_passthrough        (md),
      .result                (result),
      .cpsr_passthrough      (cpsr_pt),
      .dmem_val_passthrough  (dmem),
      .is_alu_op_passthrough (is_alu),
      .is_cmp_op_passthrough (is_cmp),
      .is_ld_op_passthrough  (is_ld),
      .if_pc_in              (pc_in),
      .if_pc_out             (pc_out),
      .exe_rd_num            (rdn),
      .exe_rd_data_out       (rd_data),
      .exe_rs_num            (rsn),
      .exe_rs_data_out       (rs_data),
      .exe_rt_num            (rtn),
      .exe_rt_data_out       (rt_data),
      .exe_cpsr_out          (cpsr_out),
      .wb_rd_num             (wb_rd_num),
      .wb_rd_write_en        (wb_rd_we),
      .wb_rd_val             (wb_rd_val),
      .wb_cpsr_write_en      (wb_cpsr_we),
      .wb_cpsr_val           (wb_cpsr_val),
      .wb_rd_out             (wb_rd_out),
      .wb_cpsr_out           (wb_cpsr_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Commit the architectural effect of the current inputs, then cross one edge.
   task automatic tick();
      if (reset) begin
         if (is_alu || is_ld) ref_gpr[rd_num] = is_ld ? dmem : result;
         if (is_cmp) ref_cpsr = cpsr_pt;
         ref_pc = pc_in;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      for (int i = 0; i < 16; i++) ref_gpr[i] = 32'h0;
      ref_cpsr = 32'h0;
      ref_pc   = 32'h0;
   endtask

   task automatic set_flags(input logic a, input logic c, input logic l);
      is_alu = a; is_cmp = c; is_ld = l;
   endtask

   // Compare every observable output against the model and the selection rules.
   task automatic check_all(input string tag);
      #1;
      chk({tag, ":rd_data"}, rd_data, ref_gpr[rdn]);
      chk({tag, ":rs_data"}, rs_data, ref_gpr[rsn]);
      chk({tag, ":rt_data"}, rt_data, ref_gpr[rtn]);
      chk({tag, ":cpsr"}, cpsr_out, ref_cpsr);
      chk({tag, ":wb_cpsr_out"}, wb_cpsr_out, ref_cpsr);
      chk({tag, ":pc"}, pc_out, ref_pc);
      chk({tag, ":wb_rd_out"}, wb_rd_out, ref_gpr[rd_num]);
      chk({tag, ":wb_rd_num"}, {28'h0, wb_rd_num}, {28'h0, rd_num});
      chk({tag, ":wb_rd_we"}, {31'h0, wb_rd_we}, {31'h0, (is_alu | is_ld)});
      if (is_ld || is_alu)
         chk({tag, ":wb_rd_val"}, wb_rd_val, is_ld ? dmem : result);
      chk({tag, ":wb_cpsr_we"}, {31'h0, wb_cpsr_we}, {31'h0, is_cmp});
      chk({tag, ":wb_cpsr_val"}, wb_cpsr_val, cpsr_pt);
   endtask

   task automatic dump_check(input string tag);
      for (int k = 0; k < 16; k++) begin
         rdn = 4'(k); rsn = 4'(k); rtn = 4'(15 - k);
         #1;
         chk({tag, ":rd"}, rd_data, ref_gpr[k]);
         chk({tag, ":rs"}, rs_data, ref_gpr[k]);
         chk({tag, ":rt"}, rt_data, ref_gpr[15 - k]);
      end
   endtask

   initial begin
      reset = 1'b0;
      rd_num = 4'h0; md = 32'h0; result = 32'h0; cpsr_pt = 32'h0; dmem = 32'h0;
      pc_in = 32'h0; rdn = 4'h0; rsn = 4'h0; rtn = 4'h0;
      set_flags(1'b0, 1'b0, 1'b0);
      model_clear();
      @(posedge clk); #1;
      @(posedge clk); #1;
      check_all("reset_state");
      reset = 1'b1;
      tick();
      check_all("released");

      // Reset: preload, then drop reset mid-cycle and look before any edge.
      set_flags(1'b1, 1'b1, 1'b0);
      rd_num = 4'd3; result = 32'hAA; cpsr_pt = 32'h5; pc_in = 32'h1234;
      tick();
      rdn = 4'd3; rsn = 4'd3; rtn = 4'd0;
      check_all("preload");
      #2;
      reset = 1'b0;
      model_clear();
      #1;
      chk("async_rst:rd", rd_data, 32'h0);
      chk("async_rst:rs", rs_data, 32'h0);
      chk("async_rst:cpsr", cpsr_out, 32'h0);
      chk("async_rst:pc", pc_out, 32'h0);
      chk("async_rst:wb_cpsr", wb_cpsr_out, 32'h0);
      tick();
      check_all("rst_blocks_write");
      reset = 1'b1;
      set_flags(1'b0, 1'b0, 1'b0);
      pc_in = 32'h0;
      tick();

      // ALU sweep.
      set_flags(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 16; i++) begin
         rd_num = 4'(i); result = 32'(i);
         tick();
         chk("alu_sweep:wb_rd_out", wb_rd_out, 32'(i));
      end
      dump_check("alu_dump");
      chk("alu_sweep:cpsr", cpsr_out, 32'h0);

      // Compare sweep: flags only, GPRs untouched.
      set_flags(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 16; i++) begin
         cpsr_pt = 32'(i); rd_num = 4'($urandom_range(15)); result = $urandom;
         tick();
         chk("cmp_sweep:wb_cpsr_out", wb_cpsr_out, 32'(i));
         check_all("cmp_sweep");
      end
      dump_check("cmp_dump");

      // Load sweep: load data, never the ALU result.
      set_flags(1'b0, 1'b0, 1'b1);
      result = 32'hDEAD;
      for (int i = 0; i < 16; i++) begin
         rd_num = 4'(i); dmem = 32'(i) + 32'h100;
         tick();
         chk("ld_sweep:wb_rd_out", wb_rd_out, 32'(i) + 32'h100);
      end
      dump_check("ld_dump");

      // Priority and idle.
      set_flags(1'b1, 1'b0, 1'b1);
      rd_num = 4'd5; result = 32'h11; dmem = 32'h22;
      tick();
      chk("prio:gpr5", wb_rd_out, 32'h22);
      set_flags(1'b0, 1'b0, 1'b0);
      result = 32'h33;
      #1;
      chk("idle:we", {31'h0, wb_rd_we}, 32'h0);
      tick();
      chk("idle:gpr5", wb_rd_out, 32'h22);

      // PC and read-during-write.
      pc_in = 32'h40;
      tick();
      chk("pc:0x40", pc_out, 32'h40);
      set_flags(1'b1, 1'b0, 1'b0);
      rd_num = 4'd7; result = 32'h77; rsn = 4'd7;
      #1;
      chk("rdw:old", rs_data, 32'h107);
      tick();
      chk("rdw:new", rs_data, 32'h77);

      // Randomized run against the model.
      for (int n = 0; n < 300; n++) begin
         set_flags(1'($urandom), 1'($urandom), 1'($urandom));
         rd_num = 4'($urandom); result = $urandom; dmem = $urandom;
         cpsr_pt = $urandom; md = $urandom; pc_in = $urandom;
         rdn = 4'($urandom); rsn = 4'($urandom);
         rtn = ($urandom_range(3) == 0) ? rsn : 4'($urandom);
         check_all("rand_pre");
         tick();
         check_all("rand_post");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/wb_regfile_unit.md
Name: wb_regfile_unit

Overview:
Writeback stage merged with the architectural register file. It selects the retiring value (ALU result or load data) and commits it to one of 16 general-purpose registers. Compare ops commit their flags to the CPSR. It also holds the PC register for fetch and provides combinational read ports to the execute stage.

Parameters:
DATA_W, 32, width of registers, PC and CPSR
NUM_REGS, 16, number of GPRs; register index is log2(NUM_REGS)=4 bits

Ports:
clk  in  1  sole clock; all state updates on rising edge
reset  in  1  asynchronous, active-low; clears all state
rd_num_passthrough  in  4  destination register from MEM stage
md_passthrough  in  32  store data passthrough; ignored by this block
result  in  32  ALU result
cpsr_passthrough  in  32  flags (NZCV in [3:0]) produced by compare
dmem_val_passthrough  in  32  load data from data memory
is_alu_op_passthrough  in  1  retiring op is ALU
is_cmp_op_passthrough  in  1  retiring op is compare
is_ld_op_passthrough  in  1  retiring op is load
if_pc_in  in  32  next PC from fetch
if_pc_out  out  32  current PC register
exe_rd_num  in  4  execute read port A index
exe_rd_data_out  out  32  GPR[exe_rd_num]
exe_rs_num  in  4  read port B index
exe_rs_data_out  out  32  GPR[exe_rs_num]
exe_rt_num  in  4  read port C index
exe_rt_data_out  out  32  GPR[exe_rt_num]
exe_cpsr_out  out  32  current CPSR
wb_rd_num  out  4  writeback destination index
wb_rd_write_en  out  1  GPR write enable
wb_rd_val  out  32  GPR write data
wb_cpsr_write_en  out  1  CPSR write enable
wb_cpsr_val  out  32  CPSR write data
wb_rd_out  out  32  debug: GPR[wb_rd_num] stored value
wb_cpsr_out  out  32  debug: stored CPSR

Behaviour:
- Writeback select (combinational):
  - wb_rd_num = rd_num_passthrough.
  - wb_rd_write_en = is_alu_op_passthrough | is_ld_op_passthrough.
  - wb_rd_val = dmem_val_passthrough if is_ld_op_passthrough, else result. Load wins if both ALU and load are set.
  - wb_cpsr_write_en = is_cmp_op_passthrough; wb_cpsr_val = cpsr_passthrough.
  - A compare never writes a GPR. ALU and load never write the CPSR.
  - All flags low: no state change.
- Reset (reset=0): all 16 GPRs, CPSR and PC clear to 0 immediately, regardless of clk. All writes are blocked while reset is low. Release is synchronous to the next rising edge.
- On each rising clk with reset=1:
  - if wb_rd_write_en, GPR[wb_rd_num] <= wb_rd_val;
  - if wb_cpsr_write_en, CPSR <= wb_cpsr_val;
  - PC <= if_pc_in unconditionally.
  - GPR and CPSR writes may occur in the same cycle.
- Reads: exe_*_data_out, exe_cpsr_out, if_pc_out, wb_rd_out and wb_cpsr_out are combinational from stored state.
- Read-during-write to the same register returns the old value. The new value is visible after the edge; there is no internal bypass.
- All 16 indices (0..15) are ordinary writable registers. Register 0 is not hardwired. The PC is a separate register, not an alias of GPR15.
- Three read ports may address the same register simultaneously; all return the same value.
- Latency: writeback commit is 1 cycle; reads are 0 cycles.

Test Plan:
- Reset: preload GPR3=0xAA, CPSR=0x5, then pulse reset low mid-cycle -> all exe read ports, exe_cpsr_out, if_pc_out and wb_cpsr_out read 0 immediately.
- ALU sweep: is_alu=1; for i=0..15 set rd_num=i, result=i, one clk each -> wb_rd_out=i after each edge; then exe_rd/rs/rt reads of index k return k; CPSR stays 0.
- Compare sweep: is_cmp=1 only; cpsr_passthrough=0..15 per clk -> wb_cpsr_out follows 0..15 one edge later. GPRs are unchanged even though rd_num/result toggle.
- Load sweep: is_ld=1 only; rd_num=i, dmem_val=i+0x100, result=0xDEAD -> GPR[i]=i+0x100, never 0xDEAD.
- Priority and idle:
  - is_alu=is_ld=1, result=0x11, dmem=0x22, rd=5 -> GPR5=0x22.
  - All flags 0 with rd=5, result=0x33 -> GPR5 stays 0x22; wb_rd_write_en=0.
- PC and read-during-write:
  - if_pc_in=0x40 -> if_pc_out=0x40 after the edge.
  - Writing GPR7=0x77 while exe_rs_num=7 -> exe_rs_data_out shows the old value before the edge and 0x77 after it.
